// File: rtl/dummy.sv
// Rolling XOR signature: each sampled word is folded into a register that
// rotates left by one bit per clock, giving a carry-free running checksum.
module dummy #(
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] data_out_o
);

    logic [DATA_W-1:0] r_in_p0;
    logic [DATA_W-1:0] r_sig_p1;

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    // Stage p0: capture the raw input word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_in_p0 <= '0;
        end else begin
            r_in_p0 <= data_in_i;
        end
    end

    // Stage p1: fold the captured word into the rotated signature
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sig_p1 <= '0;
        end else begin
            r_sig_p1 <= rotl1(r_sig_p1) ^ r_in_p0;
        end
    end

    assign data_out_o = r_sig_p1;

endmodule

// File: tb/tb_dummy.sv
// Directed bench for dummy: a 128-bit instance for reset, walk, wrap and
// alternation behaviour, plus an 8-bit instance for the narrow sequence.
module tb_dummy;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic [127:0] dout;
    logic         rst8;
    logic [7:0]   din8;
    logic [7:0]   dout8;

    int n_tests;
    int n_fail;

    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] ONE   = 128'd1;
    localparam logic [127:0] MSB   = {1'b1, 127'd0};
    localparam logic [127:0] A5REP = {16{8'hA5}};

    dummy #(.DATA_W(128)) u_dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .data_in_i  (din),
        .data_out_o (dout)
    );

    dummy #(.DATA_W(8)) u_dut8 (
        .clk_i      (clk),
        .reset_i    (rst8),
        .data_in_i  (din8),
        .data_out_o (dout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        din  = ONES;
        rst8 = 1'b1;
        din8 = 8'h00;

        // Reset hold with all-ones input
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("reset_hold_%0d", i), dout, '0);
        end

        // Release with all-ones: 0, ones, 0, ones
        rst = 1'b0;
        tick();
        check_eq("post_release_e1", dout, '0);
        tick();
        check_eq("alt_e2", dout, ONES);
        tick();
        check_eq("alt_e3", dout, '0);
        tick();
        check_eq("alt_e4", dout, ONES);

        // Single-bit walk with full wrap-around
        rst = 1'b1;
        tick();
        check_eq("reset_before_walk", dout, '0);
        rst = 1'b0;
        din = ONE;
        tick();
        check_eq("walk_first_edge", dout, '0);
        din = '0;
        tick();
        check_eq("walk_bit0", dout, ONE);
        for (int k = 1; k < 128; k++) begin
            tick();
            check_eq($sformatf("walk_bit%0d", k), dout, ONE << k);
        end
        tick();
        check_eq("walk_wrap_128", dout, ONE);

        // MSB injected directly wraps to bit 0 on the next edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din = MSB;
        tick();
        check_eq("msb_first_edge", dout, '0);
        din = '0;
        tick();
        check_eq("msb_in", dout, MSB);
        tick();
        check_eq("msb_wrap", dout, ONE);

        // Reset pulse between edges is ignored
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        check_eq("glitch_ignored", dout, 128'd2);

        // Mid-run single-cycle reset with A5 data present
        rst = 1'b1;
        din = A5REP;
        tick();
        check_eq("midrun_reset", dout, '0);
        rst = 1'b0;
        tick();
        check_eq("midrun_after_release", dout, '0);
        tick();
        check_eq("midrun_first_data", dout, A5REP);

        // Narrow instance: 0x81 then zeros
        rst8 = 1'b1;
        tick();
        check_eq("narrow_reset", {120'd0, dout8}, 128'd0);
        rst8 = 1'b0;
        din8 = 8'h81;
        tick();
        check_eq("narrow_e1", {120'd0, dout8}, 128'd0);
        din8 = 8'h00;
        tick();
        check_eq("narrow_81", {120'd0, dout8}, 128'h81);
        tick();
        check_eq("narrow_03", {120'd0, dout8}, 128'h03);
        tick();
        check_eq("narrow_06", {120'd0, dout8}, 128'h06);
        tick();
        check_eq("narrow_0c", {120'd0, dout8}, 128'h0C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
